sin_sweep_master: RTL and testbench

SIN_SWEEP_MASTER -- requirements
Module: sin_sweep_master

---
 rtl/sin_sweep_master.sv | 200 ++++++++++++++++++++
 tb/tb_sin_sweep_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sin_sweep_master.sv
// APB master that sweeps sine indices: writes the index to 0x10, reads the sample from 0x14 into a result buffer.
// Optional SIN_SWEEP_READBACK_EN adds a readback of 0x10 after each index write to verify it landed.
module sin_sweep_master #(
  parameter int NUM_POINTS     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_idx,
  input  logic [2:0]  res_addr,
  output logic [31:0] res_data,
  output logic [31:0] m_paddr,
  output logic [31:0] m_pwdata,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  input  logic        m_pready,
  input  logic        m_pslverr,
  input  logic [31:0] m_prdata
);

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]       LAST_IDX  = 3'(NUM_POINTS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      ADDR_CTRL = 32'h10;
  localparam logic [31:0]      ADDR_SINE = 32'h14;

  typedef enum logic [3:0] {
    IDLE,
    W_SETUP,
    W_ACCESS,
`ifdef SIN_SWEEP_READBACK_EN
    RB_SETUP,
    RB_ACCESS,
`endif
    R_SETUP,
    R_ACCESS,
    NEXT,
    FIN
  } state_t;

  state_t           state, state_n;
  logic [2:0]       index, index_n;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      buffer [8];
  logic             load_w, load_r, load_rb;
  logic             buf_we, set_err, clr_err, busy_set, busy_clr;
  logic             in_setup, in_access, timeout, access_fail;

  assign res_data    = buffer[res_addr];
  assign done        = (state == FIN);
  assign timeout     = !m_pready && (cnt == CNT_LAST);
  assign access_fail = (m_pready && m_pslverr) || timeout;

  always_comb begin
    state_n   = state;
    index_n   = index;
    load_w    = 1'b0;
    load_r    = 1'b0;
    load_rb   = 1'b0;
    buf_we    = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    busy_set  = 1'b0;
    busy_clr  = 1'b0;
    in_setup  = 1'b0;
    in_access = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = W_SETUP;
          index_n  = 3'd0;
          load_w   = 1'b1;
          clr_err  = 1'b1;
          busy_set = 1'b1;
        end
      end
      W_SETUP: begin
        in_setup = 1'b1;
        state_n  = W_ACCESS;
      end
      W_ACCESS: begin
        in_access = 1'b1;
        if (access_fail) begin
          set_err = 1'b1;
          state_n = FIN;
        end else if (m_pready) begin
`ifdef SIN_SWEEP_READBACK_EN
          load_rb = 1'b1;
          state_n = RB_SETUP;
`else
          load_r  = 1'b1;
          state_n = R_SETUP;
`endif
        end
      end
`ifdef SIN_SWEEP_READBACK_EN
      RB_SETUP: begin
        in_setup = 1'b1;
        state_n  = RB_ACCESS;
      end
      RB_ACCESS: begin
        in_access = 1'b1;
        if (access_fail || (m_pready && (m_prdata[2:0] != index))) begin
          set_err = 1'b1;
          state_n = FIN;
        end else if (m_pready) begin
          load_r  = 1'b1;
          state_n = R_SETUP;
        end
      end
`endif
      R_SETUP: begin
        in_setup = 1'b1;
        state_n  = R_ACCESS;
      end
      R_ACCESS: begin
        in_access = 1'b1;
        if (access_fail) begin
          set_err = 1'b1;
          state_n = FIN;
        end else if (m_pready) begin
          buf_we  = 1'b1;
          state_n = NEXT;
        end
      end
      NEXT: begin
        if (index == LAST_IDX) begin
          state_n = FIN;
        end else begin
          index_n = index + 3'd1;
          load_w  = 1'b1;
          state_n = W_SETUP;
        end
      end
      FIN: begin
        busy_clr = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Select/enable come straight from state so an async reset removes them at once.
  assign m_psel    = in_setup || in_access;
  assign m_penable = in_access;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state    <= IDLE;
      index    <= 3'd0;
      cnt      <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= 3'd0;
      m_paddr  <= '0;
      m_pwdata <= '0;
      m_pwrite <= 1'b0;
    end else begin
      state <= state_n;
      index <= index_n;
      if (in_setup)       cnt <= '0;
      else if (in_access) cnt <= cnt + 1'b1;
      if (busy_set)      busy <= 1'b1;
      else if (busy_clr) busy <= 1'b0;
      if (clr_err) begin
        err     <= 1'b0;
        err_idx <= 3'd0;
      end else if (set_err) begin
        err     <= 1'b1;
        err_idx <= index;
      end
      // Request fields are loaded on the transition into each SETUP and held afterwards.
      if (load_w) begin
        m_paddr  <= ADDR_CTRL;
        m_pwdata <= {29'b0, index_n};
        m_pwrite <= 1'b1;
      end else if (load_rb) begin
        m_paddr  <= ADDR_CTRL;
        m_pwrite <= 1'b0;
      end else if (load_r) begin
        m_paddr  <= ADDR_SINE;
        m_pwrite <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < 8; i++) buffer[i] <= '0;
    end else if (buf_we) begin
      buffer[index] <= m_prdata;
    end
  end

endmodule

// File: tb/tb_sin_sweep_master.sv
// Directed bench for sin_sweep_master: sine APB slave model with fault injection and a transfer scoreboard.
module tb_sin_sweep_master;

  logic        pclk = 1'b0;
  logic        preset, start;
  logic [2:0]  res_addr;
  logic        busy, done, err;
  logic [2:0]  err_idx;
  logic [31:0] res_data, m_paddr, m_pwdata, m_prdata;
  logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        slverr;
  } xfer_t;

  xfer_t exp_q[$];
  int    extra_cnt = 0;
  int    done_cnt  = 0;
  int    acc_cnt   = 0;

  bit          slverr_en = 0;
  logic [2:0]  slverr_idx = 3'd0;
  bit          hang_en = 0;
  bit          rb_bad_en = 0;
  logic [31:0] ctrl;

`ifdef SIN_SWEEP_READBACK_EN
  localparam int LAT_LIMIT = 90;
`else
  localparam int LAT_LIMIT = 60;
`endif

  sin_sweep_master #(.NUM_POINTS(8), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset), .start(start), .busy(busy), .done(done),
    .err(err), .err_idx(err_idx), .res_addr(res_addr), .res_data(res_data),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata)
  );

  always #5 pclk = ~pclk;

  function automatic logic [31:0] sine(input logic [2:0] i);
    case (i)
      3'd0: sine = 32'h0000_0000;
      3'd1: sine = 32'h0000_7071;
      3'd2: sine = 32'h0001_0000;
      3'd3: sine = 32'h0000_7071;
      3'd4: sine = 32'h0000_0000;
      3'd5: sine = 32'hFFFF_8F8F;
      3'd6: sine = 32'hFFFF_0000;
      default: sine = 32'hFFFF_8F8F;
    endcase
  endfunction

  // Slave: pready registered one cycle after penable; 0x10 is the index register, 0x14 the sine sample.
  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      m_pready <= 1'b0;
      ctrl     <= '0;
    end else begin
      if (m_psel && m_penable && m_pready && m_pwrite) ctrl <= m_pwdata;
      m_pready <= m_psel && m_penable && !m_pready &&
                  !(hang_en && m_pwrite && (m_pwdata[2:0] == 3'd0));
    end
  end

  always_comb begin
    m_pslverr = 1'b0;
    m_prdata  = (m_paddr == 32'h14) ? sine(ctrl[2:0]) : ctrl;
    if (slverr_en && !m_pwrite && m_paddr == 32'h14 && ctrl[2:0] == slverr_idx) begin
      m_pslverr = 1'b1;
      m_prdata  = 32'hDEAD_BEEF;
    end
    if (rb_bad_en && !m_pwrite && m_paddr == 32'h10 && ctrl[2:0] == 3'd4) m_prdata = 32'd5;
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge pclk) begin
    xfer_t got;
    xfer_t e;
    if (done) done_cnt++;
    if (m_psel && m_penable) acc_cnt++;
    if (!preset && m_psel && m_penable && m_pready) begin
      got = {m_pwrite, m_paddr, (m_pwrite ? m_pwdata : m_prdata), m_pslverr};
      if (exp_q.size() == 0) begin
        extra_cnt++;
      end else begin
        e = exp_q.pop_front();
        check("xfer", 80'(got), 80'(e));
      end
    end
  end

  task automatic push_point(input int i, input bit rd_err, input bit rb_bad);
    exp_q.push_back({1'b1, 32'h10, 32'(i), 1'b0});
`ifdef SIN_SWEEP_READBACK_EN
    exp_q.push_back({1'b0, 32'h10, (rb_bad ? 32'd5 : 32'(i)), 1'b0});
    if (rb_bad) return;
`endif
    exp_q.push_back({1'b0, 32'h14, (rd_err ? 32'hDEAD_BEEF : sine(3'(i))), rd_err});
  endtask

  task automatic clear_counts();
    #1;
    done_cnt  = 0;
    acc_cnt   = 0;
    extra_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge pclk);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen   = 0;
    while (!seen && cycles < budget) begin
      @(negedge pclk);
      cycles++;
      if (done) seen = 1;
    end
  endtask

  task automatic check_buf(input int i, input logic [31:0] exp);
    res_addr = 3'(i);
    #1;
    check($sformatf("buf%0d", i), res_data, exp);
  endtask

  task automatic settle_and_check_sweep(input string tag);
    repeat (3) @(negedge pclk);
    #1;
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_q_left"}, exp_q.size(), 0);
    check({tag, "_extra"}, extra_cnt, 0);
  endtask

  initial begin
    int cyc;
    bit seen;
    preset   = 1'b0;
    start    = 1'b0;
    res_addr = 3'd0;
    #2 preset = 1'b1;
    #1;
    check("rst_psel", m_psel, 1'b0);
    check("rst_penable", m_penable, 1'b0);
    check("rst_pwrite", m_pwrite, 1'b0);
    check("rst_paddr", m_paddr, 32'h0);
    check("rst_pwdata", m_pwdata, 32'h0);
    check("rst_busy_done_err", {busy, done, err, err_idx}, 6'b0);
    check_buf(3, 32'h0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;

    // Full sweep against the sine slave.
    clear_counts();
    for (int i = 0; i < 8; i++) push_point(i, 0, 0);
    pulse_start();
    wait_done(200, cyc, seen);
    check("sweep_done_seen", seen, 1'b1);
    check("sweep_latency_ok", (cyc <= LAT_LIMIT), 1'b1);
    check("sweep_err", err, 1'b0);
    settle_and_check_sweep("sweep");
    for (int i = 0; i < 8; i++) check_buf(i, sine(3'(i)));

    // Slave error on the sine read of index 3 aborts the sweep.
    clear_counts();
    slverr_en  = 1;
    slverr_idx = 3'd3;
    for (int i = 0; i < 3; i++) push_point(i, 0, 0);
    push_point(3, 1, 0);
    pulse_start();
    wait_done(200, cyc, seen);
    check("slverr_done_seen", seen, 1'b1);
    settle_and_check_sweep("slverr");
    check("slverr_err", {err, err_idx}, {1'b1, 3'd3});
    check_buf(3, 32'h0000_7071);
    slverr_en = 0;

    // Slave never acknowledges the first write: timeout after the access budget.
    clear_counts();
    hang_en = 1;
    pulse_start();
    wait_done(200, cyc, seen);
    check("tmo_done_seen", seen, 1'b1);
    check("tmo_psel", m_psel, 1'b0);
    settle_and_check_sweep("tmo");
    check("tmo_access_cycles", acc_cnt, 16);
    check("tmo_err", {err, err_idx}, {1'b1, 3'd0});
    check_buf(5, 32'hFFFF_8F8F);
    hang_en = 0;

    // A second start while busy is ignored.
    clear_counts();
    for (int i = 0; i < 8; i++) push_point(i, 0, 0);
    pulse_start();
    repeat (10) @(negedge pclk);
    check("busy_mid_sweep", busy, 1'b1);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    wait_done(200, cyc, seen);
    check("rstart_done_seen", seen, 1'b1);
    settle_and_check_sweep("rstart");
    check("rstart_err", err, 1'b0);

    // Asynchronous reset while reading the sample of index 2.
    clear_counts();
    for (int i = 0; i < 8; i++) push_point(i, 0, 0);
    pulse_start();
    cyc = 0;
    while (!(m_psel && m_penable && !m_pwrite && m_paddr == 32'h14 && ctrl[2:0] == 3'd2) && cyc < 100) begin
      @(negedge pclk);
      cyc++;
    end
    check("midrst_reached", (cyc < 100), 1'b1);
    #1 preset = 1'b1;
    #1;
    check("midrst_psel", m_psel, 1'b0);
    check("midrst_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    for (int i = 0; i < 8; i++) check_buf(i, 32'h0);
    check("midrst_done_cnt", done_cnt, 0);

    clear_counts();
    for (int i = 0; i < 8; i++) push_point(i, 0, 0);
    pulse_start();
    wait_done(200, cyc, seen);
    check("after_rst_done_seen", seen, 1'b1);
    settle_and_check_sweep("after_rst");
    for (int i = 0; i < 8; i++) check_buf(i, sine(3'(i)));

`ifdef SIN_SWEEP_READBACK_EN
    // Readback returns a wrong index for point 4.
    clear_counts();
    rb_bad_en = 1;
    for (int i = 0; i < 4; i++) push_point(i, 0, 0);
    push_point(4, 0, 1);
    pulse_start();
    wait_done(200, cyc, seen);
    check("rb_done_seen", seen, 1'b1);
    settle_and_check_sweep("rb");
    check("rb_err", {err, err_idx}, {1'b1, 3'd4});
    rb_bad_en = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
